// File: rtl/sr_imem_loader_pkg.sv
// sr_imem_loader_pkg: FSM state encoding and byte-lane geometry shared by the loader files.
// Latency: none (types and constants only).
// Backpressure: n/a. ST_CHECK exists only when SR_IMEM_LOADER_CHECKSUM_EN is defined.
package sr_imem_loader_pkg;

  // Width of one lane of the byte stream, independent of the CPU ISA.
  localparam int LANE_W     = 8;
  localparam int LANES      = 4;
  localparam int LANE_IDX_W = 2;

`ifdef SR_IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_CHECK = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;
`endif

endpackage

// File: rtl/sr_imem_loader_if.sv
// sr_imem_loader_if: byte-stream load channel plus CPU instruction-fetch port.
// Latency: wires only.
// Backpressure: in_ready from the loader gates in_valid; fetch port has none.
interface sr_imem_loader_if;
  import sr_imem_loader_pkg::*;

  logic              in_valid;
  logic [LANE_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;
  logic [31:0]       imAddr;
  logic [31:0]       imData;

  // master: byte source and CPU fetch side
  modport master (output in_valid, in_data, in_last, imAddr,
                  input  in_ready, imData);
  // slave: the loader itself
  modport slave  (input  in_valid, in_data, in_last, imAddr,
                  output in_ready, imData);
endinterface

// File: rtl/sr_imem_ram.sv
// sr_imem_ram: DEPTH x 32 instruction store, one synchronous write port, one async read port.
// Latency: write lands on the rising edge; read is combinational.
// Backpressure: none; contents are deliberately not reset.
module sr_imem_ram #(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [31:0]              wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [31:0]              rdata
);
  logic [31:0] mem [DEPTH];

  // single write port, no reset so a program survives a loader reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/sr_imem_loader.sv
// sr_imem_loader: loads a little-endian byte stream into instruction RAM, then releases the CPU.
// Latency: word written on its 4th (or last) byte; imData is zero-latency; cpu_rst drops 1 cycle after RUN.
// Backpressure: in_ready only in LOAD/CHECK. Optional SR_IMEM_LOADER_CHECKSUM_EN adds an XOR check byte.
module sr_imem_loader
  import sr_imem_loader_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_start,
  sr_imem_loader_if.slave        bus,
  output logic                   cpu_rst,
  output logic                   load_done,
  output logic                   load_err,
  output logic [$clog2(DEPTH):0] word_count
);
  localparam int AW = $clog2(DEPTH);

  state_t                state, state_nxt;
  logic [AW-1:0]         ptr;
  logic [LANE_IDX_W-1:0] lane;
  logic [31:0]           word_buf;
  logic [31:0]           cur_word;
  logic [31:0]           rd_word;
  logic                  accept;
  logic                  wr_en;
  logic                  start;
  logic                  at_end;
`ifdef SR_IMEM_LOADER_CHECKSUM_EN
  logic [LANE_W-1:0]     csum;
`endif

  assign start  = load_start && ((state == ST_IDLE) || (state == ST_RUN));
  assign accept = bus.in_valid && bus.in_ready;
  assign at_end = (ptr == AW'(DEPTH - 1));

  // merge the incoming byte into its lane; lanes above it are still zero
  always_comb begin
    cur_word = word_buf;
    cur_word[32'(lane) * LANE_W +: LANE_W] = bus.in_data;
  end

  // next state, stream ready and RAM write strobe
  always_comb begin
    state_nxt    = state;
    bus.in_ready = 1'b0;
    wr_en        = 1'b0;
    case (state)
      ST_IDLE, ST_RUN: begin
        if (start) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        bus.in_ready = 1'b1;
        if (accept) begin
          wr_en = bus.in_last || (lane == LANE_IDX_W'(LANES - 1));
          if (bus.in_last) begin
`ifdef SR_IMEM_LOADER_CHECKSUM_EN
            state_nxt = ST_CHECK;
`else
            state_nxt = ST_RUN;
`endif
          end else if (wr_en && at_end) begin
            state_nxt = ST_IDLE;
          end
        end
      end
`ifdef SR_IMEM_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        bus.in_ready = 1'b1;
        if (accept) state_nxt = (bus.in_data == csum) ? ST_RUN : ST_IDLE;
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // word assembly, counters, status flags and the registered CPU reset
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= '0;
      lane       <= '0;
      word_buf   <= '0;
      word_count <= '0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      cpu_rst    <= 1'b1;
`ifdef SR_IMEM_LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      cpu_rst <= (state != ST_RUN);
      if (start) begin
        ptr        <= '0;
        lane       <= '0;
        word_buf   <= '0;
        word_count <= '0;
        load_done  <= 1'b0;
        load_err   <= 1'b0;
`ifdef SR_IMEM_LOADER_CHECKSUM_EN
        csum       <= '0;
`endif
      end else begin
        if ((state == ST_LOAD) && accept) begin
`ifdef SR_IMEM_LOADER_CHECKSUM_EN
          csum <= csum ^ bus.in_data;
`endif
          if (wr_en) begin
            lane       <= '0;
            word_buf   <= '0;
            ptr        <= ptr + 1'b1;
            word_count <= word_count + 1'b1;
            if (at_end && !bus.in_last) load_err <= 1'b1;
          end else begin
            lane     <= lane + 1'b1;
            word_buf <= cur_word;
          end
        end
`ifdef SR_IMEM_LOADER_CHECKSUM_EN
        if ((state == ST_CHECK) && accept && (bus.in_data != csum)) load_err <= 1'b1;
`endif
        if ((state_nxt == ST_RUN) && (state != ST_RUN)) load_done <= 1'b1;
      end
    end
  end

  sr_imem_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (ptr),
    .wdata (cur_word),
    .raddr (bus.imAddr[AW-1:0]),
    .rdata (rd_word)
  );

  assign bus.imData = (bus.imAddr < 32'(DEPTH)) ? rd_word : 32'h0000_0000;
endmodule

// File: doc/sr_imem_loader.md
SR_IMEM_LOADER -- requirements
Module: sr_imem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning instruction memory size in 32-bit words (power of two, >=4).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port load_start  input  1  one-cycle request to begin a program load.
REQ-005 SHALL have port in_valid  input  1  byte-stream valid.
REQ-006 SHALL have port in_data  input  8  byte-stream payload.
REQ-007 SHALL have port in_last  input  1  marks the final payload byte.
REQ-008 SHALL have port in_ready  output  1  byte-stream ready.
REQ-009 SHALL have port imAddr  input  32  CPU instruction word address (already pc>>2).
REQ-010 SHALL have port imData  output  32  instruction word to the CPU.
REQ-011 SHALL have port cpu_rst  output  1  reset driven to the CPU core.
REQ-012 SHALL have ports load_done and load_err  output  1 each  status flags.
REQ-013 SHALL have port word_count  output  $clog2(DEPTH)+1  number of words written by the last or current load.

Function
REQ-014 SHALL implement states IDLE, LOAD, RUN (plus CHECK, see Configuration).
REQ-015 SHALL move IDLE->LOAD or RUN->LOAD on load_start; entry clears word pointer, byte lane, word_count, load_done, load_err.
REQ-016 SHALL assert in_ready only in LOAD; a byte is accepted when in_valid && in_ready.
REQ-017 SHALL assemble bytes little-endian (first byte -> bits 7:0) and write mem[ptr] on the 4th accepted byte, then increment ptr and word_count.
REQ-018 SHALL, on an accepted byte with in_last, write the current word zero-padded in unfilled upper lanes (even if only 1-3 bytes), increment word_count, and go to RUN.
REQ-019 SHALL, when the word at index DEPTH-1 is written without in_last, set load_err and go to IDLE; further bytes are not accepted.
REQ-020 SHALL drive imData = mem[imAddr] combinationally (zero-latency read) when imAddr < DEPTH, else 32'h0000_0000.
REQ-021 SHALL register cpu_rst = 1 in every state except RUN; cpu_rst falls on the cycle after RUN is entered and rises on the cycle after RUN is left.
REQ-022 SHALL set load_done (registered) on entry to RUN and hold it until the next load_start or rst.
REQ-023 SHALL ignore load_start while in LOAD or CHECK; in_valid outside LOAD is ignored.

Reset
REQ-024 SHALL on rst: state=IDLE, cpu_rst=1, in_ready=0, load_done=0, load_err=0, word_count=0, ptr and byte lane=0.
REQ-025 SHALL NOT clear memory contents on rst; rst mid-LOAD abandons the load, already-written words remain.

Configuration
REQ-026 SHALL, with SR_IMEM_LOADER_CHECKSUM_EN defined, go LOAD->CHECK after in_last, accept one more byte in CHECK (in_ready=1) and compare it with the XOR of all payload bytes: match -> RUN, mismatch -> load_err, IDLE.
REQ-027 SHALL, without SR_IMEM_LOADER_CHECKSUM_EN, have no CHECK state and go LOAD->RUN directly on in_last.

Structure
REQ-028 SHALL place the state enum and the RISC-V-independent byte-lane width constant in shared package sr_imem_loader_pkg.
REQ-029 SHALL use one sub-module sr_imem_ram (DEPTH x 32, one synchronous write port, one asynchronous read port, no reset).

Verification
REQ-030 SHALL cover: rst, load_start, bytes 13,00,50,00 with in_last on 4th -> mem[0]=32'h0050_0013, word_count=1, load_done=1, cpu_rst=0 two cycles after last byte.
REQ-031 SHALL cover: 6 bytes 01..06, in_last on 06 -> mem[0]=32'h0403_0201, mem[1]=32'h0000_0605, word_count=2.
REQ-032 SHALL cover: DEPTH=4, 16 bytes no in_last -> load_err=1, state IDLE, cpu_rst=1, in_ready=0, word_count=4.
REQ-033 SHALL cover: rst after 2 bytes of a load -> in_ready=0, word_count=0, cpu_rst=1; prior mem words unchanged.
REQ-034 SHALL cover: in_valid toggling 1/0 every cycle during load -> same contents as back-to-back; imAddr=DEPTH -> imData=0.
REQ-035 SHALL cover (CHECKSUM_EN): bytes 01,02,03,04 then checksum 04 -> RUN; checksum 05 -> load_err=1, cpu_rst stays 1.
